// File: rtl/baccarat_pkg.sv
// Shared card type, card value limits and the card-to-points / card-to-segment maps
// used by the baccarat hand datapath.
package baccarat_pkg;

   typedef logic [3:0] card_t;

   localparam card_t      CARD_MIN  = 4'd1;
   localparam card_t      CARD_MAX  = 4'd13;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Tens and face cards are worth nothing in baccarat.
   function automatic logic [3:0] card_points(input card_t c);
      return (c >= 4'd10) ? 4'd0 : c;
   endfunction

   // Out-of-range external values are treated as a king.
   function automatic card_t card_clamp(input card_t c);
      return ((c < CARD_MIN) || (c > CARD_MAX)) ? CARD_MAX : c;
   endfunction

   function automatic logic [6:0] card_to_seg(input card_t c);
      logic [6:0] seg;
      case (c)
         4'd1:    seg = 7'b0001000;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         4'd10:   seg = 7'b1000000;
         4'd11:   seg = 7'b1100001;
         4'd12:   seg = 7'b0011000;
         4'd13:   seg = 7'b0001001;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/baccarat_hand_datapath_card7seg_p.sv
// Combinational decoder from one stored card value to its active-low 7-seg digit (g..a).
module card7seg_p
   import baccarat_pkg::*;
(
   input  card_t      card,
   output logic [6:0] seg
);

   assign seg = card_to_seg(card);

endmodule

// File: rtl/baccarat_hand_datapath.sv
// Multi-hand baccarat datapath: card counter, per-hand slot/score registers,
// valid/ready deal port, per-hand clear and one 7-seg digit per slot.
module baccarat_hand_datapath
   import baccarat_pkg::*;
#(
   parameter int NUM_HANDS      = 2,
   parameter int CARDS_PER_HAND = 3,
   localparam int HAND_W        = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1
)(
   input  logic                                  slow_clock,
   input  logic                                  resetb,
   input  logic                                  deal_valid,
   input  logic [HAND_W-1:0]                     deal_hand,
   output logic                                  deal_ready,
   output logic                                  deal_err,
   input  logic [NUM_HANDS-1:0]                  clear_hand,
   input  logic                                  use_ext_card,
   input  logic [3:0]                            ext_card,
   output logic [NUM_HANDS*CARDS_PER_HAND*4-1:0] card_out,
   output logic [NUM_HANDS*3-1:0]                card_count,
   output logic [NUM_HANDS*4-1:0]                score_out,
   output logic [NUM_HANDS*CARDS_PER_HAND*7-1:0] hex_out
);

   localparam logic [2:0] SLOTS = 3'(CARDS_PER_HAND);

   card_t      slot_q  [NUM_HANDS][CARDS_PER_HAND];
   logic [2:0] count_q [NUM_HANDS];
   logic [3:0] score_q [NUM_HANDS];
   logic [5:0] hand_sum[NUM_HANDS];
   card_t      cnt_q;
   logic       err_q;

   logic  hand_ok, sel_full, sel_clear, accept, err_next;
   card_t src_card;

   // Deal handshake: a card moves when deal_valid and deal_ready are both high at a posedge.
   always_comb begin
      hand_ok   = 32'(deal_hand) < NUM_HANDS;
      sel_full  = 1'b0;
      sel_clear = 1'b0;
      if (hand_ok) begin
         sel_full  = (count_q[deal_hand] == SLOTS);
         sel_clear = clear_hand[deal_hand];
      end
      deal_ready = hand_ok && !sel_full && !sel_clear;
      accept     = deal_valid && deal_ready;
      // A refusal caused only by a pending clear is expected traffic, not an error.
      err_next   = deal_valid && (!hand_ok || (sel_full && !sel_clear));
      src_card   = use_ext_card ? card_clamp(ext_card) : cnt_q;
   end

   always_comb begin
      for (int h = 0; h < NUM_HANDS; h++) begin
         hand_sum[h] = '0;
         for (int s = 0; s < CARDS_PER_HAND; s++)
            hand_sum[h] = hand_sum[h] + 6'(card_points(slot_q[h][s]));
      end
   end

   always_ff @(posedge slow_clock) begin
      if (resetb) begin
         cnt_q <= CARD_MIN;
         err_q <= 1'b0;
         for (int h = 0; h < NUM_HANDS; h++) begin
            count_q[h] <= '0;
            score_q[h] <= '0;
            for (int s = 0; s < CARDS_PER_HAND; s++)
               slot_q[h][s] <= '0;
         end
      end else begin
         cnt_q <= (cnt_q == CARD_MAX) ? CARD_MIN : cnt_q + 4'd1;
         err_q <= err_next;
         for (int h = 0; h < NUM_HANDS; h++) begin
            if (clear_hand[h]) begin
               count_q[h] <= '0;
               score_q[h] <= '0;
               for (int s = 0; s < CARDS_PER_HAND; s++)
                  slot_q[h][s] <= '0;
            end else begin
               // Score follows the slots one edge later.
               score_q[h] <= 4'(hand_sum[h] % 6'd10);
               if (accept && (32'(deal_hand) == h)) begin
                  count_q[h] <= count_q[h] + 3'd1;
                  for (int s = 0; s < CARDS_PER_HAND; s++)
                     if (count_q[h] == 3'(s))
                        slot_q[h][s] <= src_card;
               end
            end
         end
      end
   end

   assign deal_err = err_q;

   for (genvar h = 0; h < NUM_HANDS; h++) begin : g_hand
      assign card_count[h*3 +: 3] = count_q[h];
      assign score_out[h*4 +: 4]  = score_q[h];
      for (genvar s = 0; s < CARDS_PER_HAND; s++) begin : g_slot
         assign card_out[(h*CARDS_PER_HAND+s)*4 +: 4] = slot_q[h][s];
         card7seg_p u_seg (
            .card (slot_q[h][s]),
            .seg  (hex_out[(h*CARDS_PER_HAND+s)*7 +: 7])
         );
      end
   end

endmodule

// File: doc/baccarat_hand_datapath.md
Name: baccarat_hand_datapath

Overview:
- Parametrised successor to the lab datapath.
- Holds NUM_HANDS hands of up to CARDS_PER_HAND cards each, on one clock.
- Deals cards from an internal 1..13 free-running card counter, or from an external test source. Uses a valid/ready deal handshake.
- Keeps a running baccarat score (sum mod 10) per hand and drives one active-low 7-seg digit per card slot.
- Sits between the game FSM (issues deals and clears) and the board HEX displays.

Parameters:
- NUM_HANDS, 2, number of hands (hand 0 = player, hand 1 = dealer by convention); range 1..4.
- CARDS_PER_HAND, 3, card slots per hand; range 1..6.

Ports:
- slow_clock  in  1  sole clock; all state updates on posedge.
- resetb  in  1  synchronous, active-high reset (1 = reset) — polarity fixed despite the name.
- deal_valid  in  1  request to deal one card.
- deal_hand  in  $clog2(NUM_HANDS) (min 1)  target hand of the deal.
- deal_ready  out  1  high when the selected hand has a free slot and no clear is pending.
- deal_err  out  1  one-cycle pulse: deal_valid to a full hand or out-of-range deal_hand.
- clear_hand  in  NUM_HANDS  per-hand synchronous clear.
- use_ext_card  in  1  1 = take card value from ext_card instead of the internal counter.
- ext_card  in  4  external card value (1..13).
- card_out  out  NUM_HANDS*CARDS_PER_HAND*4  stored card values; slot s of hand h at index h*CARDS_PER_HAND+s; 0 = empty.
- card_count  out  NUM_HANDS*3  cards held per hand.
- score_out  out  NUM_HANDS*4  registered score per hand, 0..9.
- hex_out  out  NUM_HANDS*CARDS_PER_HAND*7  active-low segments per slot, same indexing as card_out.

Behaviour:
- Reset (resetb=1 at posedge):
  - every card slot = 0, card_count = 0, score_out = 0, deal_err = 0;
  - hex_out = all 1s (blank);
  - internal counter = 1.
  - Reset mid-operation discards everything, with no partial deal.
- Internal card counter: advances 1→2→…→13→1 every slow_clock cycle, independent of deals. Never holds 0 or 14–15.
- Card source: ext_card when use_ext_card=1, else the counter's current value. ext_card values 0 or 14–15 are stored as 13 (clamped).
- Deal accepted when deal_valid & deal_ready at a posedge:
  - the card is written to slot card_count[h] of hand h;
  - card_count[h] increments at the same edge;
  - card_out and hex_out reflect the new card immediately after that edge;
  - score_out[h] updates one cycle later (edge t+1).
- deal_ready is combinational from deal_hand, card_count and clear_hand. It is low when:
  - card_count[deal_hand] == CARDS_PER_HAND,
  - clear_hand[deal_hand] = 1, or
  - deal_hand ≥ NUM_HANDS.
- deal_valid with deal_ready low:
  - no state change;
  - deal_err = 1 for the following cycle, except when the only cause is clear_hand, which is silent.
- clear_hand[h] at a posedge: slots of h = 0, card_count[h] = 0, score_out[h] = 0 at the next edge. Clear wins over a same-cycle deal to h. Deals to other hands proceed.
- Score: card value v maps to points 0 for v ≥ 10, else v; score = (sum of points of the hand's slots) mod 10. Use a 6-bit intermediate sum (max 6×9 = 54) so there is no overflow.
- 7-seg encoding (active-low, bit order g..a):
  - 0 → 1111111 (blank)
  - 1 → 0001000 ("A")
  - 2 → 0100100
  - 3 → 0110000
  - 4 → 0011001
  - 5 → 0010010
  - 6 → 0000010
  - 7 → 1111000
  - 8 → 0000000
  - 9 → 0010000
  - 10 → 1000000 ("0")
  - 11 → 1100001 ("J")
  - 12 → 0011000 ("q")
  - 13 → 0001001 ("K")
- Simultaneous clear of all hands plus a deal: all clears win, deal_err stays 0.

Decomposition:
- Package baccarat_pkg:
  - card_t (logic [3:0]);
  - CARD_MIN = 1, CARD_MAX = 13;
  - SEG_BLANK = 7'b1111111;
  - function card_points(card_t) and function card_to_seg(card_t).
- Sub-module card7seg_p (one instance per slot, combinational via card_to_seg). Generate loops over hands and slots. The counter, slot registers and score registers stay in the top module.

Test Plan:
- Reset held 2 cycles → all card_out 0, card_count 0, score_out 0, every hex_out digit 1111111, deal_ready = 1 for hand 0.
- use_ext_card=1; deal 5 then 9 to hand 0 → card_count[0] = 2, slots 5/9, hex 0010010/0010000 immediately; score_out[0] = 4 one cycle after the second deal; hand 1 digits stay blank.
- Deal 13, 12, 1 to hand 1 → score_out[1] = 1; hex K/q/A patterns; a 4th deal to hand 1 → deal_ready = 0, deal_err pulses 1 cycle, slots unchanged.
- use_ext_card=0; sample the counter over 26 cycles → values cycle 1..13 exactly twice, never 0; a dealt card equals the counter value at the accept edge.
- clear_hand[0] with a same-cycle deal to hand 0 and a deal to hand 1 → hand 0 empty/blank/score 0, hand 1 gains a card, deal_err = 0.
- Assert resetb mid-hand (hand 0 holding 2 cards) → next cycle all outputs at reset values; counter restarts at 1.
